seg_capture: RTL and testbench

//   Inverse of the hex-to-7-segment path: samples an external 7-segment bus and recovers the hex nibble.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_sync.sv | 27 ++
 rtl/seg_capture.sv | 107 ++++++++++
 tb/tb_seg_capture.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: pattern type, blank, hex glyph table, reverse lookup.
// Used by both the hex-to-segment decoder and seg_capture.
package seg_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    CAP_IDLE,
    CAP_SETTLE
  } cap_state_e;

  localparam seg_t SEG_BLANK = 7'h00;

  localparam seg_t SEG_GLYPH [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Returns {hit, nibble}; hit=0 when p is not a hex glyph.
  function automatic logic [4:0] seg_to_hex(input seg_t p);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (p == SEG_GLYPH[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_sync.sv
// Multi-stage synchronizer for the raw 7-segment pad bus.
// Async active-low reset clears every stage.
module seg_sync
  import seg_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  seg_t d,
  output seg_t q
);

  seg_t stg [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/seg_capture.sv
// Recovers hex digits from a sampled 7-segment bus with debounce and valid/ready output.
// Optional SEG_ERR_COUNT_EN adds a saturating err_count[7:0] port.
module seg_capture
  import seg_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic [3:0] out_nibble,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err_pulse,
  output logic       overrun,
  output logic       busy
`ifdef SEG_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

  seg_t       seg_s;
  seg_t       last_pat;
  seg_t       cand;
  logic [CW-1:0] cnt;
  cap_state_e state;
  logic [4:0] lut;
  logic       xfer;

  seg_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (seg_in),
    .q    (seg_s)
  );

  assign lut  = seg_to_hex(cand);
  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CAP_IDLE;
      last_pat   <= SEG_BLANK;
      cand       <= '0;
      cnt        <= '0;
      out_nibble <= '0;
      out_valid  <= 1'b0;
      err_pulse  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
`ifdef SEG_ERR_COUNT_EN
      err_count  <= '0;
`endif
    end else begin
      err_pulse <= 1'b0;
      overrun   <= 1'b0;
      if (xfer) out_valid <= 1'b0;
      unique case (state)
        CAP_IDLE: begin
          if (seg_s != last_pat) begin
            state <= CAP_SETTLE;
            busy  <= 1'b1;
            cand  <= seg_s;
            cnt   <= '0;
          end
        end
        CAP_SETTLE: begin
          if (seg_s != cand) begin
            cand <= seg_s;
            cnt  <= '0;
          end else if (cnt != CMAX) begin
            cnt <= cnt + 1'b1;
          end else begin
            state    <= CAP_IDLE;
            busy     <= 1'b0;
            last_pat <= cand;
            // A glitch that settles back onto last_pat is not a new digit.
            unique case (1'b1)
              (cand == last_pat): ;
              lut[4]: begin
                out_nibble <= lut[3:0];
                out_valid  <= 1'b1;
                overrun    <= out_valid && !out_ready;
              end
              (cand == SEG_BLANK): ;
              default: begin
                err_pulse <= 1'b1;
`ifdef SEG_ERR_COUNT_EN
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
              end
            endcase
          end
        end
        default: state <= CAP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture: directed patterns, queue of expected digits.
// Build with or without SEG_ERR_COUNT_EN.
module tb_seg_capture;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic [3:0] out_nibble;
  logic       out_valid;
  logic       out_ready;
  logic       err_pulse;
  logic       overrun;
  logic       busy;
`ifdef SEG_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int ovr_seen = 0;
  int xfers = 0;
  logic [3:0] exp_q [$];

  seg_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .out_nibble(out_nibble),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_pulse (err_pulse),
    .overrun   (overrun),
    .busy      (busy)
`ifdef SEG_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_pulse) err_seen++;
      if (overrun) ovr_seen++;
      if (out_valid && out_ready) begin
        xfers++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_xfer got=%0h expected=none", out_nibble);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (out_nibble !== e) begin
            failures++;
            $display("FAIL xfer_nibble got=%0h expected=%0h", out_nibble, e);
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    int lat;
    int e0;
    int x0;
    rst_n = 1'b0;
    seg_in = 7'h00;
    out_ready = 1'b0;
    tick(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_nibble", out_nibble, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_pulse, 0);
    chk("rst_ovr", overrun, 0);
`ifdef SEG_ERR_COUNT_EN
    chk("rst_errcnt", err_count, 0);
`endif
    rst_n = 1'b1;
    tick(2);

    // 1: latency and handshake
    seg_in = 7'h6D;
    exp_q.push_back(4'h5);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("t1_latency", lat, 7);
    chk("t1_nibble", out_nibble, 4'h5);
    out_ready = 1'b1;
    tick();
    chk("t1_valid_drop", out_valid, 0);
    chk("t1_q_empty", exp_q.size(), 0);

    // 2: bounce then settle on 1
    x0 = xfers;
    for (int i = 0; i < 10; i++) begin
      seg_in = (i % 2 == 0) ? 7'h3F : 7'h06;
      tick(2);
    end
    chk("t2_no_xfer_bounce", xfers - x0, 0);
    seg_in = 7'h06;
    exp_q.push_back(4'h1);
    tick(15);
    chk("t2_one_xfer", xfers - x0, 1);
    chk("t2_q_empty", exp_q.size(), 0);

    // 3: overrun
    out_ready = 1'b0;
    ovr_seen = 0;
    seg_in = 7'h7F;
    tick(10);
    chk("t3_valid8", out_valid, 1);
    chk("t3_nibble8", out_nibble, 4'h8);
    chk("t3_no_ovr_yet", ovr_seen, 0);
    seg_in = 7'h77;
    exp_q.push_back(4'hA);
    tick(10);
    chk("t3_ovr_once", ovr_seen, 1);
    chk("t3_valid", out_valid, 1);
    chk("t3_nibbleA", out_nibble, 4'hA);
    out_ready = 1'b1;
    tick(2);
    chk("t3_q_empty", exp_q.size(), 0);

    // 4: invalid patterns
    err_seen = 0;
    x0 = xfers;
    seg_in = 7'h01;
    tick(10);
    chk("t4_err_once", err_seen, 1);
    chk("t4_no_xfer", xfers - x0, 0);
    chk("t4_valid", out_valid, 0);
`ifdef SEG_ERR_COUNT_EN
    chk("t4_errcnt1", err_count, 1);
`endif
    for (int i = 0; i < 299; i++) begin
      seg_in = (i % 2 == 0) ? 7'h02 : 7'h01;
      tick(8);
    end
    chk("t4_err300", err_seen, 300);
`ifdef SEG_ERR_COUNT_EN
    chk("t4_errcnt_sat", err_count, 8'hFF);
`endif

    // 5: blank separates repeated digit
    err_seen = 0;
    x0 = xfers;
    seg_in = 7'h3F;
    exp_q.push_back(4'h0);
    tick(10);
    seg_in = 7'h00;
    tick(10);
    seg_in = 7'h3F;
    exp_q.push_back(4'h0);
    tick(10);
    chk("t5_two_xfer", xfers - x0, 2);
    chk("t5_no_err", err_seen, 0);
    chk("t5_q_empty", exp_q.size(), 0);

    // 6: async reset mid-settle and with pending digit
    out_ready = 1'b0;
    x0 = xfers;
    seg_in = 7'h06;
    tick(4);
    chk("t6_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", out_valid, 0);
    tick();
    rst_n = 1'b1;
    tick(10);
    chk("t6_pending_valid", out_valid, 1);
    chk("t6_pending_nib", out_nibble, 4'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst2_valid", out_valid, 0);
    chk("t6_rst2_nibble", out_nibble, 0);
`ifdef SEG_ERR_COUNT_EN
    chk("t6_rst2_errcnt", err_count, 0);
`endif
    tick();
    rst_n = 1'b1;
    exp_q.push_back(4'h1);
    tick(10);
    chk("t6_reemit_valid", out_valid, 1);
    out_ready = 1'b1;
    tick(10);
    chk("t6_one_xfer", xfers - x0, 1);
    chk("t6_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
